// File: rtl/lr_shift_seq_pkg.sv
// Shared definitions for the sequential left/right shifter.
// Direction encoding matches the flat combinational shifter.
package lr_shift_seq_pkg;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } shift_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/lr_shift_seq_if.sv
// Request/result bundle for lr_shift_seq; master is the producer/consumer side,
// slave is the shifter.
interface lr_shift_seq_if
  import lr_shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  localparam int SW = clog2(WIDTH);

  logic [WIDTH-1:0] iBits;
  logic [SW-1:0]    shift;
  shift_dir_e       dir;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] oBits;
  logic             o_valid;
  logic             o_ready;
  logic             busy;

  modport master (
    output iBits, shift, dir, i_valid, o_ready,
    input  i_ready, oBits, o_valid, busy
  );

  modport slave (
    input  iBits, shift, dir, i_valid, o_ready,
    output i_ready, oBits, o_valid, busy
  );

endinterface

// File: rtl/lr_shift_seq.sv
// One-bit-per-cycle logical shifter: result valid shift+1 cycles after accept.
// Holds one result until o_ready; in Done, i_ready follows o_ready so a new request can overlap the drain.
module lr_shift_seq
  import lr_shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  lr_shift_seq_if.slave io
);

  localparam int SW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  shift_dir_e       dir_q, dir_d;
  logic [WIDTH-1:0] step;
  logic             accept;

  // Bits pushed off the end are discarded; zero fill on the vacated side.
  always_comb begin
    step = (dir_q == RIGHT) ? (data_q >> 1) : (data_q << 1);
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    io.i_ready = 1'b0;
    io.o_valid = 1'b0;
    io.busy    = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        io.i_ready = 1'b1;
      end
      SHIFT: begin
        io.busy = 1'b1;
        if (cnt_q != '0) begin
          data_d = step;
          cnt_d  = cnt_q - SW'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        io.o_valid = 1'b1;
        io.i_ready = io.o_ready;
        if (io.o_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = io.i_valid && io.i_ready;
    if (accept) begin
      data_d  = io.iBits;
      cnt_d   = io.shift;
      dir_d   = io.dir;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= LEFT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign io.oBits = data_q;

endmodule

// File: tb/tb_lr_shift_seq.sv
// Bench for lr_shift_seq at WIDTH=8 and WIDTH=5 against a transaction-level model.
module tb_lr_shift_seq;
  import lr_shift_seq_pkg::*;

  logic clk;
  logic rst;

  logic [1:0][7:0] ibits;
  logic [1:0][2:0] sh;
  logic [1:0]      dr;
  logic [1:0]      iv;
  logic [1:0]      ordy;

  logic [1:0][7:0] obits;
  logic [1:0]      ov;
  logic [1:0]      ir;
  logic [1:0]      bz;

  logic [1:0][7:0] exp_bits;
  logic [1:0]      exp_ov;
  logic [1:0]      exp_ir;
  logic [1:0]      exp_bz;

  int n_vec;
  int n_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] b, input int s, input logic d,
                                           input int w);
    logic [31:0] x;
    x = {24'd0, b};
    x = d ? (x >> s) : (x << s);
    return 8'(x & ((32'd1 << w) - 32'd1));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int W  = (g == 0) ? 8 : 5;
    localparam int SW = clog2(W);

    lr_shift_seq_if #(.WIDTH(W)) bus ();

    assign bus.iBits   = ibits[g][W-1:0];
    assign bus.shift   = sh[g][SW-1:0];
    assign bus.dir     = shift_dir_e'(dr[g]);
    assign bus.i_valid = iv[g];
    assign bus.o_ready = ordy[g];
    assign obits[g]    = 8'(bus.oBits);
    assign ov[g]       = bus.o_valid;
    assign ir[g]       = bus.i_ready;
    assign bz[g]       = bus.busy;

    lr_shift_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
    );

    // Model: one outstanding transaction with a known result and due cycle.
    int         cyc;
    int         m_due;
    logic       m_busy;
    logic [7:0] m_res;
    logic       m_ov;
    logic       m_ir;

    assign m_ov = m_busy && (cyc >= m_due);
    assign m_ir = !m_busy || (m_ov && ordy[g]);

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        cyc    <= 0;
        m_due  <= 0;
        m_busy <= 1'b0;
        m_res  <= 8'h00;
      end else begin
        cyc <= cyc + 1;
        if (iv[g] && m_ir) begin
          m_busy <= 1'b1;
          m_res  <= ref_shift(ibits[g], int'(sh[g]), dr[g], W);
          m_due  <= cyc + 1 + int'(sh[g]) + 1;
        end else if (m_ov && ordy[g]) begin
          m_busy <= 1'b0;
        end
      end
    end

    assign exp_ov[g]   = m_ov;
    assign exp_ir[g]   = m_ir;
    assign exp_bz[g]   = m_busy && !m_ov;
    assign exp_bits[g] = m_res;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int g, input logic [7:0] b, input logic [2:0] s, input logic d,
                      input bit hold, output int edges);
    logic acc;
    ibits[g] = b;
    sh[g]    = s;
    dr[g]    = d;
    iv[g]    = 1'b1;
    edges    = 0;
    acc      = 1'b0;
    while (!acc && edges < 40) begin
      acc = ir[g];
      @(posedge clk);
      #1;
      edges++;
    end
    if (!acc) chk("accept timeout", 32'd0, 32'd1);
    if (!hold) iv[g] = 1'b0;
    ibits[g] = 8'($urandom);
    sh[g]    = 3'($urandom);
    dr[g]    = 1'($urandom);
  endtask

  task automatic expect_res(input int g, input logic [7:0] res, input int lat, input int busy_cyc);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    while (!ov[g] && n < 60) begin
      if (bz[g]) nb++;
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("i%0d latency", g), n, lat);
    chk($sformatf("i%0d result", g), obits[g], res);
    chk($sformatf("i%0d model result", g), exp_bits[g], res);
    if (busy_cyc >= 0) chk($sformatf("i%0d busy cycles", g), nb, busy_cyc);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b0;
    ibits  = '0;
    sh     = '0;
    dr     = '0;
    iv     = '0;
    ordy   = 2'b11;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("i%0d reset o_valid", g), ov[g], 1'b0);
      chk($sformatf("i%0d reset i_ready", g), ir[g], 1'b1);
      chk($sformatf("i%0d reset busy", g), bz[g], 1'b0);
      chk($sformatf("i%0d reset oBits", g), obits[g], 8'h00);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    fork
      begin
        forever begin
          @(negedge clk);
          for (int g = 0; g < 2; g++) begin
            chk($sformatf("i%0d o_valid", g), ov[g], exp_ov[g]);
            chk($sformatf("i%0d i_ready", g), ir[g], exp_ir[g]);
            chk($sformatf("i%0d busy", g), bz[g], exp_bz[g]);
            if (exp_ov[g]) chk($sformatf("i%0d oBits", g), obits[g], exp_bits[g]);
          end
        end
      end
      begin
        // Left and right shift by 3, then zero shift.
        send(0, 8'h81, 3'd3, LEFT, 1'b0, e);
        expect_res(0, 8'h08, 4, 4);
        drain();
        chk("o_valid single cycle", ov[0], 1'b0);
        send(0, 8'h81, 3'd3, RIGHT, 1'b0, e);
        expect_res(0, 8'h10, 4, 4);
        drain();
        send(0, 8'hA5, 3'd0, LEFT, 1'b0, e);
        expect_res(0, 8'hA5, 1, 1);
        drain();

        // Backpressure, then drain overlapped with the next accept.
        ordy[0] = 1'b0;
        send(0, 8'h0F, 3'd2, LEFT, 1'b0, e);
        expect_res(0, 8'h3C, 3, 3);
        for (int k = 0; k < 6; k++) begin
          drain();
          chk("held o_valid", ov[0], 1'b1);
          chk("held oBits", obits[0], 8'h3C);
          chk("held i_ready", ir[0], 1'b0);
        end
        ordy[0] = 1'b1;
        #1;
        chk("i_ready follows o_ready", ir[0], 1'b1);
        send(0, 8'hF0, 3'd4, RIGHT, 1'b0, e);
        chk("same-edge accept", e, 1);
        expect_res(0, 8'h0F, 5, 5);

        // Back-to-back with i_valid held high.
        send(0, 8'h01, 3'd1, LEFT, 1'b1, e);
        chk("b2b accept 0", e, 1);
        expect_res(0, 8'h02, 2, 2);
        send(0, 8'h02, 3'd1, LEFT, 1'b1, e);
        chk("b2b accept 1", e, 1);
        expect_res(0, 8'h04, 2, 2);
        send(0, 8'h40, 3'd1, LEFT, 1'b0, e);
        chk("b2b accept 2", e, 1);
        expect_res(0, 8'h80, 2, 2);
        drain();

        // Asynchronous reset in the middle of a shift.
        send(0, 8'hFF, 3'd7, LEFT, 1'b0, e);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst o_valid", ov[0], 1'b0);
        chk("async rst busy", bz[0], 1'b0);
        chk("async rst i_ready", ir[0], 1'b1);
        chk("async rst oBits", obits[0], 8'h00);
        drain();
        rst = 1'b1;
        send(0, 8'h01, 3'd7, LEFT, 1'b0, e);
        expect_res(0, 8'h80, 8, 8);
        drain();

        // Width 5: shift amount beyond the width clears everything.
        send(1, 8'h1F, 3'd7, LEFT, 1'b0, e);
        expect_res(1, 8'h00, 8, 8);
        drain();
        send(1, 8'h1F, 3'd2, RIGHT, 1'b0, e);
        expect_res(1, 8'h07, 3, 3);
        drain();
        drain();
      end
    join_any
    disable fork;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lr_shift_seq.md
Name: lr_shift_seq

Overview:
- Multi-cycle left/right logical bits shifter with valid/ready handshakes on both input and output sides.
- Shifts by one bit position per cycle, so no barrel shifter is needed. Used where area matters more than latency.
- Drop-in sequential counterpart to the flat combinational shifter: same ShiftDir encoding and the same width/shift sizing.
- Takes a request stream from an upstream producer and delivers the shifted result to a downstream consumer.

Parameters:
- width, 8, width of input and output bits; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- iBits  in  width  bits to shift.
- shift  in  clog2(width)  requested shift amount.
- dir  in  1  ShiftDir: Left=0, Right=1.
- i_valid  in  1  request valid.
- i_ready  out  1  request accepted when i_valid && i_ready.
- oBits  out  width  shifted result.
- o_valid  out  1  result valid.
- o_ready  in  1  result consumed when o_valid && o_ready.
- busy  out  1  high in Shift state.

Behaviour:
- Reset (rst low, asynchronous, no clock needed):
  - state=Idle; data reg=0; count=0; dir reg=Left.
  - oBits=0, o_valid=0, busy=0, i_ready=1 (driven from Idle).
- Idle:
  - i_ready=1.
  - On accept: load data reg<=iBits, count<=shift, dir reg<=dir; go to Shift.
- Shift:
  - busy=1, i_ready=0, o_valid=0.
  - If count!=0: data shifts one position in the latched dir (Left: <<1, Right: >>1), zero fill, bit shifted out is discarded; count<=count-1.
  - If count==0: go to Done; data unchanged.
- Done:
  - o_valid=1; oBits=data reg.
  - oBits and o_valid stay stable until o_ready.
  - On o_ready: go to Idle.
  - Throughput path: i_ready = o_ready in Done (combinational). A simultaneous accept loads the new request and goes directly to Shift.
- Latency: o_valid rises exactly shift+1 clock cycles after the accepting edge, including shift=0 (1 cycle).
- Inputs iBits/shift/dir are sampled only at the accept edge; later changes have no effect.
- Shift amount >= width (possible when width is not a power of 2): result is all zeros; cycle count is still shift+1.
- oBits is driven from the data reg in every state, but is meaningful only while o_valid=1.
- Reset mid-operation: the transaction is aborted with no output. Returns immediately to reset values.
- No internal buffering beyond one transaction. At most one result is outstanding.

Decomposition:
- Shared package/defs:
  - ShiftDir enum (Left=0, Right=1), shared with the flat shifter.
  - State enum (Idle=0, Shift=1, Done=2), 2-bit encoding.
  - clog2 function.
- Single module; no sub-module needed.
- The one-bit step is a local combinational expression.

Test Plan:
- Left shift: width=8, iBits=0x81, shift=3, dir=Left, o_ready=1 -> oBits=0x08, o_valid high 4 cycles after accept for 1 cycle, busy high 4 cycles.
- Right shift and zero shift: iBits=0x81, shift=3, dir=Right -> 0x10 after 4 cycles. Then iBits=0xA5, shift=0 -> 0xA5 after 1 cycle.
- Backpressure: iBits=0x0F, shift=2, Left, o_ready=0 for 6 cycles after o_valid -> o_valid=1, oBits=0x3C stable, i_ready=0. On o_ready=1 with i_valid=1 (0xF0, shift 4, Right) -> both accepted same edge; next result 0x0F.
- Back-to-back: o_ready=1, i_valid=1 always, shift=1 Left on 0x01,0x02,0x40 -> results 0x02,0x04,0x80, one result every 2 cycles.
- Reset mid-shift: accept 0xFF, shift=7, Left; assert rst low 3 cycles later between edges -> o_valid=0, busy=0, i_ready=1, oBits=0 without a clock edge. After release, 0x01 shift 7 Left -> 0x80 after 8 cycles.
- Non-power-of-2: width=5, iBits=0x1F, shift=7, Left -> oBits=0x00 after 8 cycles. Same setup with shift=2, Right -> 0x07.
